// File: rtl/alu_mc_if.sv
// Start/Busy/Done operand and result bundle for the multi-cycle ALU.
// The master drives the request side; the ALU is the slave.
interface alu_mc_if #(
  parameter int W   = 8,
  parameter int OPW = 4
);
  logic           Start;
  logic [OPW-1:0] Op;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           Busy;
  logic           Done;
  logic [W-1:0]   Result;
  logic           Zero;
  logic           Sign;
  logic           Carry;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, Result, Zero, Sign, Carry
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, Result, Zero, Sign, Carry
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-edge arithmetic/logic, iterative one-bit-per-edge shifts.
// Optional macro ALU_MC_MUL_EN adds an iterative shift-add multiplier on opcode 10.
module alu_mc #(
  parameter int W   = 8,
  parameter int OPW = 4
) (
  input logic     Clk,
  input logic     Reset,
  alu_mc_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [W:0]    wext_t;

  localparam cnt_t  CNT_W   = cnt_t'(W);
  localparam cnt_t  CNT_ONE = cnt_t'(1'b1);
  localparam wext_t W_EXT   = wext_t'(W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef ALU_MC_MUL_EN
  localparam logic [1:0] ST_MUL   = 2'd2;
`endif

  localparam logic [OPW-1:0] OP_ADD   = OPW'(4'd0);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(4'd1);
  localparam logic [OPW-1:0] OP_ADC   = OPW'(4'd2);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(4'd3);
  localparam logic [OPW-1:0] OP_AND   = OPW'(4'd4);
  localparam logic [OPW-1:0] OP_OR    = OPW'(4'd5);
  localparam logic [OPW-1:0] OP_SHL   = OPW'(4'd6);
  localparam logic [OPW-1:0] OP_SHR   = OPW'(4'd7);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(4'd8);
  localparam logic [OPW-1:0] OP_PASSB = OPW'(4'd9);
`ifdef ALU_MC_MUL_EN
  localparam logic [OPW-1:0] OP_MUL   = OPW'(4'd10);
`endif

  localparam logic [1:0] SK_SHL = 2'd0;
  localparam logic [1:0] SK_SHR = 2'd1;
  localparam logic [1:0] SK_SRA = 2'd2;

  logic [1:0]   state_r;
  logic         busy_r;
  logic         done_r;
  logic [W-1:0] result_r;
  logic         zero_r;
  logic         sign_r;
  logic         carry_r;
  logic [W-1:0] work_r;
  cnt_t         cnt_r;
  logic [1:0]   skind_r;

`ifdef ALU_MC_MUL_EN
  logic [2*W-1:0] acc_r;
  logic [2*W-1:0] mcand_r;
  logic [W-1:0]   mplier_r;
  logic [2*W-1:0] acc_next_s;
`endif

  logic         is_shift_s;
  logic [1:0]   skind_s;
  cnt_t         k_s;
  logic         multi_s;
  logic [W:0]   sum_s;
  logic [W-1:0] one_res_s;
  logic         one_carry_s;
  logic [W-1:0] sh_next_s;
  logic         sh_out_s;
  logic         cmp_en_s;
  logic [W-1:0] cmp_res_s;
  logic         cmp_carry_s;

  // Decode: is the request multi-cycle, and what is the clamped shift amount.
  always_comb begin
    is_shift_s = 1'b0;
    skind_s    = SK_SHL;
    k_s        = '0;
    multi_s    = 1'b0;
    case (bus.Op)
      OP_SHL: begin
        is_shift_s = 1'b1;
        skind_s    = SK_SHL;
      end
      OP_SHR: begin
        is_shift_s = 1'b1;
        skind_s    = SK_SHR;
      end
      OP_SRA: begin
        is_shift_s = 1'b1;
        skind_s    = SK_SRA;
      end
      default: begin
        is_shift_s = 1'b0;
        skind_s    = SK_SHL;
      end
    endcase
    if ({1'b0, bus.B} >= W_EXT) begin
      k_s = CNT_W;
    end else begin
      k_s = bus.B[CW-1:0];
    end
    if (is_shift_s && (k_s != '0)) begin
      multi_s = 1'b1;
    end else begin
      multi_s = 1'b0;
    end
`ifdef ALU_MC_MUL_EN
    if (bus.Op == OP_MUL) begin
      multi_s = 1'b1;
    end else begin
      multi_s = multi_s;
    end
`endif
  end

  // Single-edge result; shift opcodes land here only when the amount is zero.
  always_comb begin
    sum_s       = '0;
    one_res_s   = '0;
    one_carry_s = carry_r;
    case (bus.Op)
      OP_ADD: begin
        sum_s       = {1'b0, bus.A} + {1'b0, bus.B};
        one_res_s   = sum_s[W-1:0];
        one_carry_s = sum_s[W];
      end
      OP_SUB: begin
        // A + ~B + 1: carry out is the not-borrow flag
        sum_s       = {1'b0, bus.A} + {1'b0, ~bus.B} + {{W{1'b0}}, 1'b1};
        one_res_s   = sum_s[W-1:0];
        one_carry_s = sum_s[W];
      end
      OP_ADC: begin
        sum_s       = {1'b0, bus.A} + {1'b0, bus.B} + {{W{1'b0}}, carry_r};
        one_res_s   = sum_s[W-1:0];
        one_carry_s = sum_s[W];
      end
      OP_XOR:   one_res_s = bus.A ^ bus.B;
      OP_AND:   one_res_s = bus.A & bus.B;
      OP_OR:    one_res_s = bus.A | bus.B;
      OP_PASSB: one_res_s = bus.B;
      OP_SHL, OP_SHR, OP_SRA: begin
        one_res_s   = bus.A;
        one_carry_s = 1'b0;
      end
      default: begin
        one_res_s   = '0;
        one_carry_s = carry_r;
      end
    endcase
  end

  // One-bit shift step of the working register and the bit that falls out.
  always_comb begin
    sh_next_s = work_r;
    sh_out_s  = 1'b0;
    case (skind_r)
      SK_SHL: begin
        sh_next_s = {work_r[W-2:0], 1'b0};
        sh_out_s  = work_r[W-1];
      end
      SK_SHR: begin
        sh_next_s = {1'b0, work_r[W-1:1]};
        sh_out_s  = work_r[0];
      end
      SK_SRA: begin
        sh_next_s = {work_r[W-1], work_r[W-1:1]};
        sh_out_s  = work_r[0];
      end
      default: begin
        sh_next_s = work_r;
        sh_out_s  = 1'b0;
      end
    endcase
  end

`ifdef ALU_MC_MUL_EN
  // Partial-product accumulation for the current multiplier bit.
  always_comb begin
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end
`endif

  // Completion select: which value, if any, is committed on this edge.
  always_comb begin
    cmp_en_s    = 1'b0;
    cmp_res_s   = one_res_s;
    cmp_carry_s = one_carry_s;
    case (state_r)
      ST_IDLE: begin
        if (bus.Start && !multi_s) begin
          cmp_en_s = 1'b1;
        end else begin
          cmp_en_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        cmp_res_s   = sh_next_s;
        cmp_carry_s = sh_out_s;
        if (cnt_r == CNT_ONE) begin
          cmp_en_s = 1'b1;
        end else begin
          cmp_en_s = 1'b0;
        end
      end
`ifdef ALU_MC_MUL_EN
      ST_MUL: begin
        cmp_res_s   = acc_next_s[W-1:0];
        cmp_carry_s = |acc_next_s[2*W-1:W];
        if (cnt_r == CNT_ONE) begin
          cmp_en_s = 1'b1;
        end else begin
          cmp_en_s = 1'b0;
        end
      end
`endif
      default: begin
        cmp_en_s = 1'b0;
      end
    endcase
  end

  // Control FSM: operand capture, iteration counter and Busy.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      work_r  <= '0;
      cnt_r   <= '0;
      skind_r <= SK_SHL;
`ifdef ALU_MC_MUL_EN
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.Start && multi_s) begin
            busy_r <= 1'b1;
`ifdef ALU_MC_MUL_EN
            if (bus.Op == OP_MUL) begin
              state_r  <= ST_MUL;
              cnt_r    <= CNT_W;
              acc_r    <= '0;
              mcand_r  <= {{W{1'b0}}, bus.A};
              mplier_r <= bus.B;
            end else begin
              state_r <= ST_SHIFT;
              cnt_r   <= k_s;
              work_r  <= bus.A;
              skind_r <= skind_s;
            end
`else
            state_r <= ST_SHIFT;
            cnt_r   <= k_s;
            work_r  <= bus.A;
            skind_r <= skind_s;
`endif
          end
        end
        ST_SHIFT: begin
          work_r <= sh_next_s;
          cnt_r  <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
`ifdef ALU_MC_MUL_EN
        ST_MUL: begin
          acc_r    <= acc_next_s;
          mcand_r  <= {mcand_r[2*W-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[W-1:1]};
          cnt_r    <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Result and flag registers; they move only on a completion edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      done_r   <= 1'b0;
      result_r <= '0;
      zero_r   <= 1'b0;
      sign_r   <= 1'b0;
      carry_r  <= 1'b0;
    end else begin
      done_r <= cmp_en_s;
      if (cmp_en_s) begin
        result_r <= cmp_res_s;
        zero_r   <= (cmp_res_s == '0);
        sign_r   <= cmp_res_s[W-1];
        carry_r  <= cmp_carry_s;
      end
    end
  end

  assign bus.Busy   = busy_r;
  assign bus.Done   = done_r;
  assign bus.Result = result_r;
  assign bus.Zero   = zero_r;
  assign bus.Sign   = sign_r;
  assign bus.Carry  = carry_r;

  alu_mc_chk #(.W(W)) u_chk (
    .clk    (Clk),
    .reset  (Reset),
    .busy   (busy_r),
    .done   (done_r),
    .idle   (state_r == ST_IDLE),
    .result (result_r)
  );

endmodule

// Handshake invariants of alu_mc.
module alu_mc_chk #(
  parameter int W = 8
) (
  input logic         clk,
  input logic         reset,
  input logic         busy,
  input logic         done,
  input logic         idle,
  input logic [W-1:0] result
);

  a_done_not_busy: assert property (@(posedge clk) disable iff (reset) done |-> !busy);
  a_busy_state:    assert property (@(posedge clk) busy == !idle);
  a_result_hold:   assert property (@(posedge clk) disable iff (reset)
                                    busy |=> (!busy || $stable(result)));

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (W=8, OPW=4); observed tuple is
// {Result, Zero, Sign, Carry}.
module tb_alu_mc;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_mc_if #(.W(8), .OPW(4)) bus ();

  alu_mc #(.W(8), .OPW(4)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] obs();
    return {bus.Result, bus.Zero, bus.Sign, bus.Carry};
  endfunction

  // Issue one request and return the number of edges after capture until Done (-1 on timeout).
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.A = 8'hA5; bus.B = 8'h5A; bus.Op = 4'd3;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      if (bus.Done === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.Busy, bus.Done, obs()} !== 13'h0) begin
      failures++;
      $display("FAIL reset busy/done/res/flags got=%h exp=0", {bus.Busy, bus.Done, obs()});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add_adc();
    int lat;
    run_op(4'd0, 8'hF0, 8'h20, lat);
    checks++;
    if ({lat[7:0], obs()} !== {8'd0, 8'h10, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL add lat/res got=%0d/%h exp=0/%h", lat, obs(), {8'h10, 3'b001});
    end
    run_op(4'd2, 8'h01, 8'h01, lat);
    checks++;
    if ({lat[7:0], obs()} !== {8'd0, 8'h03, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL adc lat/res got=%0d/%h exp=0/%h", lat, obs(), {8'h03, 3'b000});
    end
  endtask

  task automatic test_sub();
    int lat;
    run_op(4'd1, 8'h05, 8'h05, lat);
    checks++;
    if ({lat[7:0], obs()} !== {8'd0, 8'h00, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL sub_eq lat/res got=%0d/%h exp=0/%h", lat, obs(), {8'h00, 3'b101});
    end
    run_op(4'd1, 8'h03, 8'h04, lat);
    checks++;
    if ({lat[7:0], obs()} !== {8'd0, 8'hFF, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sub_borrow lat/res got=%0d/%h exp=0/%h", lat, obs(), {8'hFF, 3'b010});
    end
  endtask

  task automatic test_logic();
    logic [3:0]  op_t [5] = '{4'd0, 4'd3, 4'd4, 4'd5, 4'd9};
    logic [7:0]  a_t  [5] = '{8'hFF, 8'h0F, 8'h0F, 8'h50, 8'h12};
    logic [7:0]  b_t  [5] = '{8'h01, 8'hF0, 8'h3C, 8'h0A, 8'h80};
    logic [10:0] e_t  [5] = '{{8'h00, 3'b101}, {8'hFF, 3'b011}, {8'h0C, 3'b001},
                              {8'h5A, 3'b001}, {8'h80, 3'b011}};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(op_t[i], a_t[i], b_t[i], lat);
      checks++;
      if ({lat[7:0], obs()} !== {8'd0, e_t[i]}) begin
        failures++;
        $display("FAIL logic[%0d] lat/res got=%0d/%h exp=0/%h", i, lat, obs(), e_t[i]);
      end
    end
  endtask

  task automatic test_shifts();
    logic [3:0]  op_t [8] = '{4'd6, 4'd8, 4'd7, 4'd7, 4'd6, 4'd8, 4'd6, 4'd8};
    logic [7:0]  a_t  [8] = '{8'h81, 8'h80, 8'h96, 8'h96, 8'h01, 8'h90, 8'hFF, 8'h40};
    logic [7:0]  b_t  [8] = '{8'd3, 8'd200, 8'd0, 8'd8, 8'd1, 8'd2, 8'd9, 8'd8};
    logic [10:0] e_t  [8] = '{{8'h08, 3'b000}, {8'hFF, 3'b011}, {8'h96, 3'b010},
                              {8'h00, 3'b101}, {8'h02, 3'b000}, {8'hE4, 3'b010},
                              {8'h00, 3'b101}, {8'h00, 3'b100}};
    int          l_t  [8] = '{3, 8, 0, 8, 1, 2, 8, 8};
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(op_t[i], a_t[i], b_t[i], lat);
      checks++;
      if (lat !== l_t[i] || obs() !== e_t[i]) begin
        failures++;
        $display("FAIL shift[%0d] lat/res got=%0d/%h exp=%0d/%h", i, lat, obs(), l_t[i], e_t[i]);
      end
    end
  endtask

  task automatic test_dropped_start();
    int busy_cnt = 0;
    int done_cnt = 0;
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = 4'd6; bus.A = 8'h81; bus.B = 8'd3;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.Busy === 1'b1) busy_cnt++;
      if (bus.Done === 1'b1) done_cnt++;
      if (i == 0) begin
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = 4'd0; bus.A = 8'h01; bus.B = 8'h01;
      end
      @(posedge clk); #1;
      bus.Start = 1'b0;
    end
    checks++;
    if (busy_cnt !== 3 || done_cnt !== 1) begin
      failures++;
      $display("FAIL drop busy/done cycles got=%0d/%0d exp=3/1", busy_cnt, done_cnt);
    end
    checks++;
    if (obs() !== {8'h08, 3'b000}) begin
      failures++;
      $display("FAIL drop result got=%h exp=%h", obs(), {8'h08, 3'b000});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op_t [4] = '{4'd0, 4'd0, 4'd5, 4'd4};
    logic [7:0] a_t  [4] = '{8'h01, 8'h10, 8'h0F, 8'hAA};
    logic [7:0] b_t  [4] = '{8'h02, 8'h20, 8'hF0, 8'h0F};
    logic [7:0] e_t  [4] = '{8'h03, 8'h30, 8'hFF, 8'h0A};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.Start = 1'b1; bus.Op = op_t[i]; bus.A = a_t[i]; bus.B = b_t[i];
      @(posedge clk); #1;
      checks++;
      if ({bus.Done, bus.Busy, bus.Result} !== {1'b1, 1'b0, e_t[i]}) begin
        failures++;
        $display("FAIL b2b[%0d] done/busy/res got=%b/%b/%h exp=1/0/%h",
                 i, bus.Done, bus.Busy, bus.Result, e_t[i]);
      end
    end
    @(negedge clk);
    bus.Start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.Done, bus.Result} !== {1'b0, 8'h0A}) begin
      failures++;
      $display("FAIL b2b_idle done/res got=%b/%h exp=0/0a", bus.Done, bus.Result);
    end
  endtask

  task automatic test_reset_abort();
    int done_cnt = 0;
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = 4'd6; bus.A = 8'h81; bus.B = 8'd5;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.Busy, bus.Done, obs()} !== 13'h0) begin
      failures++;
      $display("FAIL abort busy/done/res/flags got=%h exp=0", {bus.Busy, bus.Done, obs()});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.Done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0 || bus.Result !== 8'h00) begin
      failures++;
      $display("FAIL abort late_done/res got=%0d/%h exp=0/00", done_cnt, bus.Result);
    end
  endtask

  task automatic test_op10();
    int lat;
`ifdef ALU_MC_MUL_EN
    run_op(4'd10, 8'h10, 8'h11, lat);
    checks++;
    if (lat !== 8 || obs() !== {8'h10, 3'b001}) begin
      failures++;
      $display("FAIL mul_hi lat/res got=%0d/%h exp=8/%h", lat, obs(), {8'h10, 3'b001});
    end
    run_op(4'd10, 8'h0F, 8'h0F, lat);
    checks++;
    if (lat !== 8 || obs() !== {8'hE1, 3'b010}) begin
      failures++;
      $display("FAIL mul_lo lat/res got=%0d/%h exp=8/%h", lat, obs(), {8'hE1, 3'b010});
    end
`else
    run_op(4'd0, 8'h80, 8'h80, lat);
    run_op(4'd10, 8'h12, 8'h34, lat);
    checks++;
    if (lat !== 0 || obs() !== {8'h00, 3'b101}) begin
      failures++;
      $display("FAIL op10_illegal lat/res got=%0d/%h exp=0/%h", lat, obs(), {8'h00, 3'b101});
    end
`endif
  endtask

  task automatic test_illegal();
    int lat;
    run_op(4'd0, 8'hFF, 8'hFF, lat);
    checks++;
    if (obs() !== {8'hFE, 3'b011}) begin
      failures++;
      $display("FAIL ill_setup res got=%h exp=%h", obs(), {8'hFE, 3'b011});
    end
    run_op(4'd11, 8'hFF, 8'hFF, lat);
    checks++;
    if (lat !== 0 || obs() !== {8'h00, 3'b101}) begin
      failures++;
      $display("FAIL ill_11 lat/res got=%0d/%h exp=0/%h", lat, obs(), {8'h00, 3'b101});
    end
    run_op(4'd15, 8'h7F, 8'h80, lat);
    checks++;
    if (lat !== 0 || obs() !== {8'h00, 3'b101}) begin
      failures++;
      $display("FAIL ill_15 lat/res got=%0d/%h exp=0/%h", lat, obs(), {8'h00, 3'b101});
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.Start = 1'b0;
    bus.Op = 4'd0;
    bus.A = 8'h00;
    bus.B = 8'h00;
    test_reset();
    test_add_adc();
    test_sub();
    test_logic();
    test_shifts();
    test_dropped_start();
    test_back_to_back();
    test_reset_abort();
    test_op10();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU for the CPU datapath. It is the successor to the combinational 8-bit ALU.
- Adds a Start/Busy/Done handshake, registered Result and flags, and a sticky Carry usable by ADC.
- Shifts run iteratively, one bit per cycle, so the datapath needs no barrel shifter.
- Sits between the register file read ports and the writeback mux; the control FSM stalls on Busy.

Parameters:
W, 8, operand/result width (≥4)
OPW, 4, opcode width (≥4)

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous active-high reset
Start  in  1  request; sampled only when Busy=0
Op  in  OPW  opcode, captured with Start
A  in  W  operand A, captured with Start
B  in  W  operand B / shift amount, captured with Start
Busy  out  1  operation in progress; Start ignored while high
Done  out  1  one-cycle pulse: Result and flags updated on the preceding edge
Result  out  W  registered result; holds until the next completion
Zero  out  1  Result==0, registered with Result
Sign  out  1  Result[W-1], registered with Result
Carry  out  1  sticky carry flag (see per-op rules)

Behaviour:
- Reset:
  - Busy, Done, Result, Zero, Sign and Carry are all 0; state is IDLE.
  - Reset mid-operation aborts the operation; no Done is produced and captured operands are discarded.
- States:
  - IDLE: accepts Start.
  - SHIFT: iterative shift.
  - MUL: present only with the optional feature.
- Opcodes:
  - 0 ADD: A+B; Carry = carry out.
  - 1 SUB: A-B; Carry = 1 when no borrow (A≥B unsigned).
  - 2 ADC: A+B+Carry; Carry = carry out.
  - 3 XOR, 4 AND, 5 OR: Carry unchanged.
  - 6 SHL: logical left shift.
  - 7 SHR: logical right shift.
  - 8 SRA: arithmetic right shift.
  - 9 PASSB: Result = B; Carry unchanged.
  - 10 MUL: optional, see below.
  - 11..max ILLEGAL: Result = 0, Zero = 1, Sign = 0, Carry unchanged.
- Single-cycle ops (0-5, 9, illegal, and shifts with amount 0):
  - Start=1 in IDLE at edge e0 → Result and flags loaded at e0; Done=1 and Busy=0 for the cycle after e0.
  - Latency is 1 edge.
- Shifts (6-8):
  - Shift amount k = min(B, W); B is treated as unsigned.
  - For k≥1: operands are latched at e0, state goes to SHIFT, and Busy=1.
  - Exactly one bit position shifts per edge, at e1..ek; an internal counter decrements and the working register is internal.
  - At ek, Result and flags are loaded, Busy drops, and Done pulses in the following cycle. Latency is k edges after e0.
  - Carry = last bit shifted out; for k=0, Carry = 0.
  - k=W gives Result = 0 for SHL/SHR and all-sign bits for SRA.
- Zero and Sign are recomputed on every completion.
- Result and flags change only at completion edges, never while Busy=1.
- Back-to-back operation:
  - Busy is low during the Done cycle, so a Start in the Done cycle is accepted.
  - A single-cycle op issued every cycle gives Done continuously high, and Result updates every edge.
- A Start while Busy=1 is dropped and is not queued.
- Op, A and B may change freely after capture.
- All arithmetic is modulo 2^W; the carry comes from a W+1-bit sum.

Optional Feature:
ALU_MC_MUL_EN:
- Defined: opcode 10 MUL performs an unsigned shift-add multiply.
  - Operands are latched at e0, state goes to MUL, and one partial product is accumulated per edge for W edges.
  - Result = low W bits of A*B; Carry = 1 if the high W bits are nonzero.
  - Zero and Sign are taken from Result; latency is W edges; Busy/Done follow the shift rules.
- Undefined: opcode 10 behaves as ILLEGAL, no MUL state or accumulator is synthesised, and latency is 1.

Test Plan:
- W=8, ADD A=0xF0 B=0x20 → after 1 edge: Done=1, Result=0x10, Carry=1, Zero=0, Sign=0; next op ADC A=0x01 B=0x01 → Result=0x03, Carry=0.
- SUB A=0x05 B=0x05 → Result=0x00, Zero=1, Carry=1; SUB A=0x03 B=0x04 → Result=0xFF, Sign=1, Carry=0.
- SHL A=0x81 B=3 → Busy high for 3 cycles; Done exactly 3 edges after Start; Result=0x08, Carry=0. SRA A=0x80 B=200 → 8 edges, Result=0xFF, Carry=1. SHR B=0 → 1 edge, Result=A, Carry=0.
- Start pulsed during a SHIFT with Op=ADD → ignored; exactly one Done, for the shift only; Result unaffected by the dropped request.
- Reset asserted on the 2nd cycle of SHL B=5 → next cycle: Busy=0, Done=0, Result=0, all flags 0; no Done ever appears for the aborted op.
- With ALU_MC_MUL_EN: MUL A=0x10 B=0x11 → Done after 8 edges, Result=0x10, Carry=1. Without it: opcode 10 → 1 edge, Result=0, Zero=1.
